// File: rtl/i2s_frame_deserializer_if.sv
// i2s_frame_deserializer_if: valid/ready sample stream from the I2S deserializer to the FFT sink
interface i2s_frame_deserializer_if #(parameter int DATA_W = 24);
  logic [DATA_W-1:0] source_data;
  logic source_channel;
  logic source_valid;
  logic source_ready;
  logic source_sop;
  logic source_eop;
  modport master (output source_data, source_channel, source_valid, source_sop, source_eop, input source_ready);
  modport slave (input source_data, source_channel, source_valid, source_sop, source_eop, output source_ready);
endinterface

// File: rtl/i2s_frame_deserializer.sv
// i2s_frame_deserializer: oversampled I2S capture into FFT-framed valid/ready words
// Define I2S_ERR_CNT_EN to add the saturating err_count output.
module i2s_frame_deserializer #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int FRAME_LEN = 128,
  parameter int CHANNEL_MODE = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic BCLK,
  input  logic ADCLRC,
  input  logic din,
  input  logic err_clr,
  output logic overrun,
  output logic short_slot,
`ifdef I2S_ERR_CNT_EN
  output logic [15:0] err_count,
`endif
  i2s_frame_deserializer_if.master src
);
  localparam int CW = $clog2(SLOT_W + 1);
  localparam int IW = $clog2(FRAME_LEN);
  typedef enum logic [2:0] {IDLE, SYNC, SKIP, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [1:0] bclk_s, lr_s, din_s;
  logic bclk_d, lr_prev, ch, word_rdy;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] sr;
  logic rise, lr_edge, shift_en, done, short_ev, keep, load, ov_ev;
  assign rise = bclk_s[1] & ~bclk_d;
  assign lr_edge = rise & (lr_s[1] ^ lr_prev);
  assign keep = (CHANNEL_MODE == 2) || (ch == 1'(CHANNEL_MODE));
  // A finished word may enter only an empty register or one being drained this cycle
  assign load = word_rdy & enable & (~src.source_valid | src.source_ready);
  assign ov_ev = word_rdy & enable & ~load;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    shift_en = 1'b0;
    done = 1'b0;
    short_ev = 1'b0;
    if (!enable) nxt = IDLE;
    else
      case (state)
        IDLE: nxt = SYNC;
        SYNC: nxt = (lr_edge && !lr_s[1]) ? SKIP : SYNC;
        SKIP: nxt = (rise && !lr_edge) ? SHIFT : SKIP;
        SHIFT: begin
          short_ev = lr_edge;
          shift_en = rise & ~lr_edge;
          done = shift_en & (cnt == CW'(DATA_W - 1));
          nxt = lr_edge ? SKIP : done ? DONE : SHIFT;
        end
        DONE: nxt = lr_edge ? SKIP : DONE;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bclk_s <= '0;
      lr_s <= '0;
      din_s <= '0;
      bclk_d <= 1'b0;
      lr_prev <= 1'b0;
      ch <= 1'b0;
      cnt <= '0;
      sr <= '0;
      word_rdy <= 1'b0;
      idx <= '0;
      src.source_valid <= 1'b0;
      src.source_data <= '0;
      src.source_channel <= 1'b0;
      src.source_sop <= 1'b0;
      src.source_eop <= 1'b0;
      overrun <= 1'b0;
      short_slot <= 1'b0;
    end else begin
      bclk_s <= {bclk_s[0], BCLK};
      lr_s <= {lr_s[0], ADCLRC};
      din_s <= {din_s[0], din};
      bclk_d <= bclk_s[1];
      if (rise) lr_prev <= lr_s[1];
      if (lr_edge) begin
        ch <= lr_s[1];
        cnt <= '0;
      end else if (shift_en) cnt <= cnt + CW'(1);
      if (shift_en) sr <= {sr[DATA_W-2:0], din_s[1]};
      word_rdy <= done & keep;
      if (state == IDLE) idx <= '0;
      else if (load) idx <= idx + IW'(1);
      if (load) begin
        src.source_valid <= 1'b1;
        src.source_data <= sr;
        src.source_channel <= ch;
        src.source_sop <= idx == '0;
        src.source_eop <= idx == IW'(FRAME_LEN - 1);
      end else if (src.source_ready) src.source_valid <= 1'b0;
      overrun <= ov_ev | (overrun & ~err_clr);
      short_slot <= short_ev | (short_slot & ~err_clr);
    end
`ifdef I2S_ERR_CNT_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) err_count <= '0;
    else if (err_clr) err_count <= {15'd0, ov_ev | short_ev};
    else if ((ov_ev | short_ev) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: doc/i2s_frame_deserializer.md
Name: i2s_frame_deserializer

Overview:
Parametrised successor of the audio-codec SIPO front end. Oversamples I2S BCLK/ADCLRC/DIN on one system clock and deserialises configurable-width samples from a selected channel or both. Emits an FFT-ready valid/ready stream with per-frame sop/eop, plus overrun and short-slot error flags. Sits between the codec serial pins and the FFT sink.

Parameters:
DATA_W, 24, captured bits per sample, MSB first, 8..32
SLOT_W, 32, BCLK periods per LRCLK half-period, DATA_W..64
FRAME_LEN, 128, words per FFT frame, power of two, 2..4096
CHANNEL_MODE, 0, 0 = left only, 1 = right only, 2 = both, interleaved L then R

Ports:
clock  in  1  system clock; must be at least 8x BCLK
reset_n  in  1  asynchronous active-low reset
enable  in  1  capture enable
BCLK  in  1  codec bit clock, asynchronous
ADCLRC  in  1  codec word select, asynchronous; 0 = left, 1 = right
din  in  1  codec serial data, asynchronous
source_data  out  DATA_W  sample word
source_channel  out  1  0 = left, 1 = right
source_valid  out  1  word valid
source_ready  in  1  sink accepts word
source_sop  out  1  first word of frame, qualified by source_valid
source_eop  out  1  last word of frame, qualified by source_valid
overrun  out  1  sticky: word dropped because the output was still held
short_slot  out  1  sticky: LRCLK toggled before DATA_W bits were captured
err_clr  in  1  single-cycle clear of both sticky flags

Behaviour:
- Reset: all outputs 0; synchronisers 0; frame index 0; FSM in IDLE.
- BCLK, ADCLRC and din each pass through a 2-FF synchroniser. A BCLK rise is detected as sync=1 and delayed=0. All serial actions occur only on a detected rise.
- LRCLK edge: detected when sync ADCLRC differs from its value at the previous BCLK rise. This sets the current slot channel to the new ADCLRC value and resets the bit counter.
- I2S one-bit delay: the first BCLK rise after an LRCLK edge is skipped. The next DATA_W rises shift din into the shift register MSB first. Rises beyond DATA_W in the slot are ignored.
- FSM states:
  - IDLE: entered while enable=0. On enable=1, go to SYNC.
  - SYNC: wait for an LRCLK falling edge (start of left slot), then go to SKIP. Frame index is reset to 0 on entering SYNC.
  - SKIP: one BCLK rise, then go to SHIFT.
  - SHIFT: count DATA_W rises, then go to DONE. An LRCLK edge here discards the partial word, sets short_slot and returns to SKIP.
  - DONE: wait for the next LRCLK edge, then go to SKIP.
- Channel filter: in modes 0/1, only slots of the selected channel produce words; other slots are still tracked for framing. In mode 2, both slots produce words.
- Output load: the clock after the last shifted bit, the word is loaded into the output register if it is empty, or if source_valid and source_ready are both 1 in that same cycle.
  - On load: source_valid=1; source_sop = (index==0); source_eop = (index==FRAME_LEN-1); index increments modulo FRAME_LEN.
  - Otherwise the word is dropped, overrun is set, and the index is not advanced.
- Handshake: source_data, source_channel, source_sop and source_eop stay stable while source_valid=1 and source_ready=0. source_valid falls the cycle after acceptance unless a new word loads in the same cycle.
- Latency: source_valid rises 3 clock cycles after the clock edge that first samples BCLK high at the pin during the LSB bit.
- Mode 2 framing: the index counts words, so a frame holds FRAME_LEN/2 L/R pairs and always starts on a left word.
- enable falling mid-frame: the current word is abandoned. An already-held output word still completes its handshake. The next enable restarts the frame at index 0 on a left slot.
- err_clr together with a new error event in the same cycle: the flag ends set.
- reset_n asserted at any time: immediate return to reset values; any partial frame is lost.

Optional Feature:
I2S_ERR_CNT_EN: when defined, adds output err_count [15:0]. It increments on every overrun or short_slot event and saturates at 16'hFFFF. err_clr also clears it; with simultaneous err_clr and an event, the result is 1. When undefined, the port and counter are absent and the flags behave as above.

Test Plan:
- Mode 0, DATA_W=24, SLOT_W=32, BCLK = clock/8, left words 24'h800001 and 24'h7FFFFE; ready=1 -> source_data 800001 then 7FFFFE, channel=0, valid high 1 cycle each, no right words.
- FRAME_LEN=4, mode 2, 8 slots, ready=1 -> sop on words 0 and 4, eop on words 3 and 7, channel sequence 0,1,0,1,...
- ready=0 for 3 slots in mode 2 -> first word held stable, next two dropped, overrun=1; with I2S_ERR_CNT_EN, err_count=2; err_clr -> both 0.
- ADCLRC toggled after 10 bits with DATA_W=24 -> no word, short_slot=1, next full slot captured correctly.
- enable dropped at index 2 of FRAME_LEN=4, then re-enabled during a right slot -> first output is a left word with sop=1.
- reset_n pulsed low mid-SHIFT with source_valid=1 -> all outputs 0 at once; the first word after release carries sop=1.
